// File: rtl/conv_pkg.sv
// Shared types and helpers for the parallel 1-D convolution block.
// Holds the control states and a width-parameterised signed saturation.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD_F  = 2'd0,
        LOAD_X  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int SAT_W = 64;

    // Clamp a wide signed value into the signed range of a w-bit word (w <= 32).
    function automatic logic signed [SAT_W-1:0] sat_w(input logic signed [SAT_W-1:0] v,
                                                      input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/conv1d_par_stream_if.sv
// Stream bundle for the convolution block: filter in, samples in, results out.
// Handshake: a word moves on a rising edge where valid and ready are both 1; ready never
// depends combinationally on the same stream's valid, and a sender holds data while stalled.
interface conv1d_par_stream_if #(parameter int WIDTH = 8);
    logic signed [WIDTH-1:0] s_data_in_f;
    logic                    s_valid_f;
    logic                    s_ready_f;
    logic signed [WIDTH-1:0] s_data_in_x;
    logic                    s_valid_x;
    logic                    s_ready_x;
    logic signed [WIDTH-1:0] m_data_out_y;
    logic                    m_valid_y;
    logic                    m_ready_y;

    modport slave (
        input  s_data_in_f, s_valid_f, s_data_in_x, s_valid_x, m_ready_y,
        output s_ready_f, s_ready_x, m_data_out_y, m_valid_y
    );

    modport master (
        output s_data_in_f, s_valid_f, s_data_in_x, s_valid_x, m_ready_y,
        input  s_ready_f, s_ready_x, m_data_out_y, m_valid_y
    );
endinterface

// File: rtl/conv_mac_lane.sv
// One multiply-accumulate lane: the product and every running sum saturate to WIDTH bits.
// clr wins over en so the accumulator can restart in the same cycle its result is taken.
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] f_in,
    output logic signed [WIDTH-1:0] acc
);
    logic signed [2*WIDTH-1:0] x_ext;
    logic signed [2*WIDTH-1:0] f_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [SAT_W-1:0]   prod_sat;
    logic signed [WIDTH-1:0]   acc_q, acc_d;

    always_comb begin
        x_ext    = {{WIDTH{x_in[WIDTH-1]}}, x_in};
        f_ext    = {{WIDTH{f_in[WIDTH-1]}}, f_in};
        prod     = x_ext * f_ext;
        prod_sat = sat_w({{(SAT_W-2*WIDTH){prod[2*WIDTH-1]}}, prod}, WIDTH);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = WIDTH'(sat_w({{(SAT_W-WIDTH){acc_q[WIDTH-1]}}, acc_q} + prod_sat, WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: rtl/conv1d_par_stream.sv
// Parallel-lane 1-D convolution: filter loaded once, then each input vector is convolved
// P outputs at a time (LENF+1 cycles per group) and results stream out in index order.
module conv1d_par_stream
    import conv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int P     = 2,
    parameter int RELU  = 1
) (
    input  logic               clk,
    input  logic               reset,
    conv1d_par_stream_if.slave bus,
    output state_t             dbg_state
);
    localparam int SIZE = LENX - LENF + 1;
    localparam int G    = (SIZE + P - 1) / P;
    localparam int CW   = $clog2(LENX + 2);

    typedef logic [CW-1:0]           cnt_t;
    typedef logic signed [WIDTH-1:0] word_t;

    localparam cnt_t ONE     = cnt_t'(1);
    localparam cnt_t LAST_F  = cnt_t'(LENF - 1);
    localparam cnt_t LAST_X  = cnt_t'(LENX - 1);
    localparam cnt_t STEP_WR = cnt_t'(LENF);
    localparam cnt_t LAST_G  = cnt_t'(G - 1);
    localparam cnt_t LAST_Y  = cnt_t'(SIZE - 1);
    localparam cnt_t SIZE_C  = cnt_t'(SIZE);

    state_t state_q, state_d;
    cnt_t   load_cnt_q, load_cnt_d;
    cnt_t   step_q, step_d;
    cnt_t   grp_q, grp_d;
    cnt_t   wr_cnt_q, wr_cnt_d;
    cnt_t   rd_ptr_q, rd_ptr_d;
    word_t  f_mem_q [LENF];
    word_t  f_mem_d [LENF];
    word_t  x_mem_q [LENX];
    word_t  x_mem_d [LENX];
    word_t  y_mem_q [SIZE];
    word_t  y_mem_d [SIZE];

    int             base;
    logic [P-1:0]   lane_live;
    logic [P-1:0]   lane_en;
    logic           lane_clr;
    word_t          lane_f;
    word_t          lane_x   [P];
    word_t          lane_acc [P];
    word_t          y_data;
    logic           f_fire, x_fire, y_fire;

    assign bus.s_ready_f    = (state_q == LOAD_F);
    assign bus.s_ready_x    = (state_q == LOAD_X);
    assign bus.m_valid_y    = (rd_ptr_q < wr_cnt_q);
    assign bus.m_data_out_y = y_data;
    assign dbg_state        = state_q;

    assign f_fire = bus.s_valid_f && bus.s_ready_f;
    assign x_fire = bus.s_valid_x && bus.s_ready_x;
    assign y_fire = bus.m_valid_y && bus.m_ready_y;

    // Lane i of group g works on output g*P+i; lanes past the last output stay idle.
    always_comb begin
        base   = int'(grp_q) * P;
        lane_f = '0;
        for (int j = 0; j < LENF; j++) begin
            if (cnt_t'(j) == step_q) lane_f = f_mem_q[j];
        end
        for (int i = 0; i < P; i++) begin
            lane_live[i] = (base + i) < SIZE;
            lane_en[i]   = (state_q == COMPUTE) && (step_q != STEP_WR) && lane_live[i];
            lane_x[i]    = '0;
            for (int k = 0; k < LENX; k++) begin
                if (k == base + i + int'(step_q)) lane_x[i] = x_mem_q[k];
            end
        end
    end

    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        conv_mac_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .reset (reset),
            .en    (lane_en[gi]),
            .clr   (lane_clr),
            .x_in  (lane_x[gi]),
            .f_in  (lane_f),
            .acc   (lane_acc[gi])
        );
    end

    always_comb begin
        y_data = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (cnt_t'(k) == rd_ptr_q) y_data = y_mem_q[k];
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        step_d     = step_q;
        grp_d      = grp_q;
        wr_cnt_d   = wr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        f_mem_d    = f_mem_q;
        x_mem_d    = x_mem_q;
        y_mem_d    = y_mem_q;
        lane_clr   = 1'b0;
        case (state_q)
            LOAD_F: if (f_fire) begin
                for (int k = 0; k < LENF; k++) begin
                    if (cnt_t'(k) == load_cnt_q) f_mem_d[k] = bus.s_data_in_f;
                end
                if (load_cnt_q == LAST_F) begin
                    load_cnt_d = '0;
                    state_d    = LOAD_X;
                end else begin
                    load_cnt_d = load_cnt_q + ONE;
                end
            end
            LOAD_X: if (x_fire) begin
                for (int k = 0; k < LENX; k++) begin
                    if (cnt_t'(k) == load_cnt_q) x_mem_d[k] = bus.s_data_in_x;
                end
                if (load_cnt_q == LAST_X) begin
                    load_cnt_d = '0;
                    step_d     = '0;
                    grp_d      = '0;
                    state_d    = COMPUTE;
                end else begin
                    load_cnt_d = load_cnt_q + ONE;
                end
            end
            COMPUTE: begin
                if (step_q != STEP_WR) begin
                    step_d = step_q + ONE;
                end else begin
                    // Write cycle: store lane sums (ReLU applied only here) and restart lanes.
                    step_d   = '0;
                    lane_clr = 1'b1;
                    for (int i = 0; i < P; i++) begin
                        for (int k = 0; k < SIZE; k++) begin
                            if (lane_live[i] && k == base + i) begin
                                y_mem_d[k] = (RELU != 0 && lane_acc[i] < 0) ? '0 : lane_acc[i];
                            end
                        end
                    end
                    wr_cnt_d = (base + P >= SIZE) ? SIZE_C : cnt_t'(base + P);
                    if (grp_q == LAST_G) state_d = DRAIN;
                    else                 grp_d   = grp_q + ONE;
                end
            end
            DRAIN:   ;
            default: state_d = LOAD_F;
        endcase
        // The last result can only be readable in DRAIN, so its transfer ends the vector.
        if (y_fire) begin
            if (rd_ptr_q == LAST_Y) begin
                rd_ptr_d = '0;
                wr_cnt_d = '0;
                state_d  = LOAD_X;
            end else begin
                rd_ptr_d = rd_ptr_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD_F;
            load_cnt_q <= '0;
            step_q     <= '0;
            grp_q      <= '0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            for (int k = 0; k < LENF; k++) f_mem_q[k] <= '0;
            for (int k = 0; k < LENX; k++) x_mem_q[k] <= '0;
            for (int k = 0; k < SIZE; k++) y_mem_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            step_q     <= step_d;
            grp_q      <= grp_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            f_mem_q    <= f_mem_d;
            x_mem_q    <= x_mem_d;
            y_mem_q    <= y_mem_d;
        end
    end
endmodule

// File: doc/conv1d_par_stream.md
CONV1D_PAR_STREAM -- requirements
Module: conv1d_par_stream

Interface
REQ-001 Parameter WIDTH, default 8: signed sample, coefficient and result width in bits.
REQ-002 Parameter LENX, default 8: input vector length N.
REQ-003 Parameter LENF, default 4: filter length M, 2 <= LENF <= LENX.
REQ-004 Parameter P, default 2: parallel MAC lanes, 1 <= P <= LENX-LENF+1.
REQ-005 Parameter RELU, default 1: 1 clamps negative results to 0; 0 passes signed results.
REQ-006 Derived constants: SIZE = LENX-LENF+1 outputs; G = ceil(SIZE/P) groups.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 s_data_in_f  in  WIDTH  signed filter coefficient stream, f[0] first.
REQ-010 s_valid_f / s_ready_f  in / out  1  filter handshake.
REQ-011 s_data_in_x  in  WIDTH  signed input sample stream, x[0] first.
REQ-012 s_valid_x / s_ready_x  in / out  1  input handshake.
REQ-013 m_data_out_y  out  WIDTH  signed result, y[0] first.
REQ-014 m_valid_y / m_ready_y  out / in  1  output handshake.

Function
REQ-015 Transfers occur only on cycles where valid and ready are both 1; ready is a registered or state-derived signal and does not depend combinationally on the same interface's valid.
REQ-016 States: LOAD_F, LOAD_X, COMPUTE, DRAIN; reset enters LOAD_F.
REQ-017 LOAD_F: s_ready_f=1, s_ready_x=0; after exactly LENF filter transfers, go to LOAD_X; the filter is retained until the next reset.
REQ-018 LOAD_X: s_ready_x=1, s_ready_f=0; after exactly LENX input transfers, go to COMPUTE.
REQ-019 y[k] = sum over j=0..LENF-1 of x[k+j]*f[j], for k=0..SIZE-1.
REQ-020 COMPUTE processes group g (outputs gP..gP+P-1) in exactly LENF+1 cycles: LENF accumulate cycles plus 1 cycle writing the lane results to the output buffer.
REQ-021 Lanes with index gP+i >= SIZE in the last group are disabled and write nothing.
REQ-022 After the write cycle of group G-1, go to DRAIN.
REQ-023 Each product is saturated to WIDTH signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1] before accumulation, and each accumulate step is saturated to the same range.
REQ-024 When RELU=1, any result below 0 is stored as 0; the accumulator itself is not clamped mid-sum.
REQ-025 The output buffer holds SIZE entries; m_valid_y=1 whenever written-but-unread entries exist, including during COMPUTE; results are emitted strictly in index order.
REQ-026 m_data_out_y holds stable while m_valid_y=1 and m_ready_y=0.
REQ-027 DRAIN: when y[SIZE-1] transfers, return to LOAD_X with the read and write pointers cleared; s_ready_x rises on the next cycle.
REQ-028 Computation never stalls on m_ready_y, because buffer capacity equals SIZE.
REQ-029 s_valid_f asserted outside LOAD_F is ignored; s_valid_x asserted outside LOAD_X is ignored.

Reset
REQ-030 On reset, outputs take these values on the next edge: s_ready_f=1, s_ready_x=0, m_valid_y=0, m_data_out_y=0.
REQ-031 On reset, all counters, pointers and accumulators clear to 0.
REQ-032 Reset asserted in any state, including mid-COMPUTE or mid-DRAIN, aborts the operation; buffered results and the stored filter are discarded.

Structure
REQ-033 Shared package conv_pkg holds the state enum and a saturating function parameterised by WIDTH.
REQ-034 One sub-module, conv_mac_lane, contains the multiply, saturate and accumulate datapath for a single lane, with enable and clear inputs; the top instantiates P of them.
REQ-035 Sample and coefficient storage are register arrays, so all P lanes read in parallel.

Verification (WIDTH=8, LENX=8, LENF=4, P=2 unless stated)
REQ-036 Basic: f={1,1,1,1}, x=1..8, m_ready_y=1 -> y=10,14,18,22,26; m_valid_y first rises within LENF+2 cycles of the last x transfer.
REQ-037 Saturation: f={2,2,2,2}, x all 100 -> every product clamps to 127 and every y=127; with f all -2, every y=-128 when RELU=0 and 0 when RELU=1.
REQ-038 Backpressure: m_ready_y randomly toggled at 50% -> identical y sequence, no drops or duplicates, data stable while stalled, s_ready_x=0 until y[4] transfers.
REQ-039 Reuse: second vector x=8..1 with no filter reload -> y=26,22,18,14,10.
REQ-040 Partial group: P=3 (SIZE=5, G=2) -> exactly 5 outputs; the disabled lane writes nothing.
REQ-041 Reset mid-COMPUTE -> next cycle s_ready_f=1, m_valid_y=0; reload filter and vector -> correct y.
